// File: rtl/attitude_pid_mixer.sv
`default_nettype none
// ============================================================================
// Module  : attitude_pid_mixer
// Brief   : 3-axis PID on one shared signed MAC, feeding an X-quad motor mixer.
// Revision: 1.0
// ============================================================================
module attitude_pid_mixer #(
  parameter int DATA_W     = 16,
  parameter int COEF_W     = 16,
  parameter int ACC_W      = 40,
  parameter int FRAC_SHIFT = 8,
  parameter int INT_LIM    = 8192,
  parameter int OUT_W      = 16,
  parameter int OUT_MIN    = 256,
  parameter int OUT_MAX    = 65000,
  parameter int KP_DEF     = 100,
  parameter int KI_DEF     = 10,
  parameter int KD_DEF     = 50
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arm,
  input  logic                  gain_we,
  input  logic [3:0]            gain_addr,
  input  logic [COEF_W-1:0]     gain_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OUT_W-1:0]      throttle,
  input  logic [3*DATA_W-1:0]   target,
  input  logic [3*DATA_W-1:0]   meas,
  output logic                  out_valid,
  output logic [OUT_W-1:0]      pwm_m1,
  output logic [OUT_W-1:0]      pwm_m2,
  output logic [OUT_W-1:0]      pwm_m3,
  output logic [OUT_W-1:0]      pwm_m4,
  output logic                  sat_flag
);

  localparam int E_W = DATA_W + 1;
  localparam int D_W = DATA_W + 2;
  localparam int I_W = DATA_W + 2;

  localparam logic signed [I_W:0]     c_ilim_hi   = (I_W+1)'(INT_LIM);
  localparam logic signed [I_W:0]     c_ilim_lo   = (I_W+1)'(-INT_LIM);
  localparam logic signed [ACC_W-1:0] c_out_min   = ACC_W'(OUT_MIN);
  localparam logic signed [ACC_W-1:0] c_out_max   = ACC_W'(OUT_MAX);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ERR  = 3'd1,
    S_MAC  = 3'd2,
    S_MIX  = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  state_t                   r_state;
  logic                     r_arm;
  logic [OUT_W-1:0]         r_thr;
  logic [3*DATA_W-1:0]      r_target;
  logic [3*DATA_W-1:0]      r_meas;
  logic signed [E_W-1:0]    r_err  [3];
  logic signed [E_W-1:0]    r_prev [3];
  logic signed [D_W-1:0]    r_der  [3];
  logic signed [I_W-1:0]    r_int  [3];
  logic [COEF_W-1:0]        r_gain [9];
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [ACC_W-1:0]  r_u    [3];
  logic [1:0]               r_axis;
  logic [1:0]               r_term;

  logic signed [DATA_W-1:0] w_tgt   [3];
  logic signed [DATA_W-1:0] w_mes   [3];
  logic signed [E_W-1:0]    w_err   [3];
  logic signed [D_W-1:0]    w_der   [3];
  logic signed [I_W:0]      w_isum  [3];
  logic signed [I_W-1:0]    w_iclamp[3];
  logic [3:0]               w_gidx;
  logic signed [ACC_W-1:0]  w_opnd;
  logic signed [ACC_W-1:0]  w_coef;
  logic signed [ACC_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_thr;
  logic signed [ACC_W-1:0]  w_mix   [4];
  logic [OUT_W-1:0]         w_pwm   [4];
  logic                     w_sat;

  // Error, derivative and saturating integral for all three axes in parallel
  always_comb begin
    for (int a = 0; a < 3; a++) begin
      w_tgt[a]  = r_target[a*DATA_W +: DATA_W];
      w_mes[a]  = r_meas[a*DATA_W +: DATA_W];
      w_err[a]  = E_W'(w_tgt[a]) - E_W'(w_mes[a]);
      w_der[a]  = D_W'(w_err[a]) - D_W'(r_prev[a]);
      w_isum[a] = (I_W+1)'(r_int[a]) + (I_W+1)'(w_err[a]);
      if (w_isum[a] > c_ilim_hi)
        w_iclamp[a] = I_W'(c_ilim_hi);
      else if (w_isum[a] < c_ilim_lo)
        w_iclamp[a] = I_W'(c_ilim_lo);
      else
        w_iclamp[a] = w_isum[a][I_W-1:0];
    end
  end

  // Shared MAC: operand selected by term, gain zero-extended before the signed multiply
  always_comb begin
    w_gidx = 4'(r_axis) * 4'd3 + 4'(r_term);
    w_coef = $signed({{(ACC_W-COEF_W){1'b0}}, r_gain[w_gidx]});
    case (r_term)
      2'd0:    w_opnd = ACC_W'(r_err[r_axis]);
      2'd1:    w_opnd = ACC_W'(r_int[r_axis]);
      2'd2:    w_opnd = ACC_W'(r_der[r_axis]);
      default: w_opnd = '0;
    endcase
    w_prod = w_opnd * w_coef;
    w_sum  = r_acc + w_prod;
  end

  always_comb begin
    w_thr    = $signed({{(ACC_W-OUT_W){1'b0}}, r_thr});
    w_mix[0] = w_thr - r_u[0] - r_u[1] - r_u[2];
    w_mix[1] = w_thr - r_u[0] + r_u[1] + r_u[2];
    w_mix[2] = w_thr + r_u[0] - r_u[1] + r_u[2];
    w_mix[3] = w_thr + r_u[0] + r_u[1] - r_u[2];
    w_sat    = 1'b0;
    for (int m = 0; m < 4; m++) begin
      if (w_mix[m] < c_out_min) begin
        w_pwm[m] = c_out_min[OUT_W-1:0];
        w_sat    = 1'b1;
      end else if (w_mix[m] > c_out_max) begin
        w_pwm[m] = c_out_max[OUT_W-1:0];
        w_sat    = 1'b1;
      end else begin
        w_pwm[m] = w_mix[m][OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      pwm_m1    <= '0;
      pwm_m2    <= '0;
      pwm_m3    <= '0;
      pwm_m4    <= '0;
      sat_flag  <= 1'b0;
      r_arm     <= 1'b0;
      r_thr     <= '0;
      r_target  <= '0;
      r_meas    <= '0;
      r_acc     <= '0;
      r_axis    <= '0;
      r_term    <= '0;
      for (int a = 0; a < 3; a++) begin
        r_err[a]  <= '0;
        r_prev[a] <= '0;
        r_der[a]  <= '0;
        r_int[a]  <= '0;
        r_u[a]    <= '0;
        r_gain[a*3]   <= COEF_W'(KP_DEF);
        r_gain[a*3+1] <= COEF_W'(KI_DEF);
        r_gain[a*3+2] <= COEF_W'(KD_DEF);
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (gain_we && gain_addr <= 4'd8)
            r_gain[gain_addr] <= gain_data;
          if (in_valid) begin
            r_arm    <= arm;
            r_thr    <= throttle;
            r_target <= target;
            r_meas   <= meas;
            in_ready <= 1'b0;
            r_state  <= S_ERR;
          end
        end
        S_ERR: begin
          // A disarmed sample wipes the loop history so re-arming starts clean
          for (int a = 0; a < 3; a++) begin
            if (r_arm) begin
              r_err[a]  <= w_err[a];
              r_der[a]  <= w_der[a];
              r_prev[a] <= w_err[a];
              r_int[a]  <= w_iclamp[a];
            end else begin
              r_err[a]  <= '0;
              r_der[a]  <= '0;
              r_prev[a] <= '0;
              r_int[a]  <= '0;
            end
          end
          r_acc   <= '0;
          r_axis  <= '0;
          r_term  <= '0;
          r_state <= S_MAC;
        end
        S_MAC: begin
          if (r_term == 2'd2) begin
            r_u[r_axis] <= w_sum >>> FRAC_SHIFT;
            r_acc       <= '0;
            r_term      <= '0;
            if (r_axis == 2'd2)
              r_state <= S_MIX;
            else
              r_axis <= r_axis + 2'd1;
          end else begin
            r_acc  <= w_sum;
            r_term <= r_term + 2'd1;
          end
        end
        S_MIX: begin
          out_valid <= 1'b1;
          if (r_arm) begin
            pwm_m1   <= w_pwm[0];
            pwm_m2   <= w_pwm[1];
            pwm_m3   <= w_pwm[2];
            pwm_m4   <= w_pwm[3];
            sat_flag <= w_sat;
          end else begin
            pwm_m1   <= '0;
            pwm_m2   <= '0;
            pwm_m3   <= '0;
            pwm_m4   <= '0;
            sat_flag <= 1'b0;
          end
          r_state <= S_OUT;
        end
        S_OUT: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_attitude_pid_mixer.sv
`default_nettype none
// ============================================================================
// Module  : tb_attitude_pid_mixer
// Brief   : Directed-vector bench for attitude_pid_mixer.
// Revision: 1.0
// ============================================================================
module tb_attitude_pid_mixer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm;
  logic        gain_we;
  logic [3:0]  gain_addr;
  logic [15:0] gain_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] throttle;
  logic [47:0] target;
  logic [47:0] meas;
  logic        out_valid;
  logic [15:0] pwm_m1, pwm_m2, pwm_m3, pwm_m4;
  logic        sat_flag;

  int n_assert = 0;
  int n_fail   = 0;

  attitude_pid_mixer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arm       (arm),
    .gain_we   (gain_we),
    .gain_addr (gain_addr),
    .gain_data (gain_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .throttle  (throttle),
    .target    (target),
    .meas      (meas),
    .out_valid (out_valid),
    .pwm_m1    (pwm_m1),
    .pwm_m2    (pwm_m2),
    .pwm_m3    (pwm_m3),
    .pwm_m4    (pwm_m4),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int e1, input int e2, input int e3,
                         input int e4, input int es);
    chk({tag, ".m1"}, 32'(pwm_m1), 32'(e1));
    chk({tag, ".m2"}, 32'(pwm_m2), 32'(e2));
    chk({tag, ".m3"}, 32'(pwm_m3), 32'(e3));
    chk({tag, ".m4"}, 32'(pwm_m4), 32'(e4));
    chk({tag, ".sat"}, 32'(sat_flag), 32'(es));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  task automatic gain_wr(input logic [3:0] addr, input logic [15:0] data);
    wait_idle();
    gain_we = 1'b1; gain_addr = addr; gain_data = data;
    @(posedge clk); #1;
    gain_we = 1'b0;
  endtask

  // wmode: 0 none, 1 gain write in the accept cycle, 2 gain write while busy
  task automatic sample(input string tag, input logic a, input int thr, input int tp,
                        input int mp, input int tr, input int ty, input int wmode,
                        input logic [3:0] waddr, input logic [15:0] wdata);
    int n = 0;
    wait_idle();
    arm = a; throttle = thr[15:0];
    target = {ty[15:0], tr[15:0], tp[15:0]};
    meas   = {32'd0, mp[15:0]};
    in_valid = 1'b1;
    if (wmode == 1) begin gain_we = 1'b1; gain_addr = waddr; gain_data = wdata; end
    @(posedge clk); #1;
    in_valid = 1'b0; gain_we = 1'b0;
    target = '1; meas = '1; throttle = '1; arm = ~a;
    do begin
      if (wmode == 2 && n == 3) begin gain_we = 1'b1; gain_addr = waddr; gain_data = wdata; end
      @(posedge clk); #1;
      gain_we = 1'b0;
      n++;
    end while (!out_valid && n < 30);
    chk({tag, ".latency"}, 32'(n), 32'd11);
  endtask

  initial begin
    int ip, up, seen;
    rst_n = 1'b0; arm = 1'b0; gain_we = 1'b0; gain_addr = '0; gain_data = '0;
    in_valid = 1'b0; throttle = '0; target = '0; meas = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk_out("reset", 0, 0, 0, 0, 0);

    // Default gains, zero error -> throttle passes straight through
    sample("t1", 1'b1, 30000, 0, 0, 0, 0, 0, 4'd0, 16'd0);
    chk_out("t1", 30000, 30000, 30000, 30000, 0);
    @(posedge clk); #1;
    chk("t1.out_valid_pulse", 32'(out_valid), 32'd0);
    chk("t1.hold_m1", 32'(pwm_m1), 32'd30000);

    // Pitch P only, Kp=256 -> up = 100
    gain_wr(4'd0, 16'd256);
    gain_wr(4'd1, 16'd0);
    gain_wr(4'd2, 16'd0);
    sample("t2", 1'b1, 30000, 100, 0, 0, 0, 0, 4'd0, 16'd0);
    chk_out("t2", 29900, 29900, 30100, 30100, 0);

    sample("t3dis", 1'b0, 30000, 0, 0, 0, 0, 0, 4'd0, 16'd0);
    chk_out("t3dis", 0, 0, 0, 0, 0);

    // Pitch I only, Ki=1: up = I>>8 with I climbing 1000/sample to the 8192 clamp
    gain_wr(4'd0, 16'd0);
    gain_wr(4'd1, 16'd1);
    for (int k = 1; k <= 20; k++) begin
      sample("t3", 1'b1, 30000, 1500, 500, 0, 0, 0, 4'd0, 16'd0);
      ip = (1000 * k > 8192) ? 8192 : 1000 * k;
      up = ip >>> 8;
      if (k == 1 || k == 8 || k == 9 || k == 20)
        chk_out($sformatf("t3.k%0d", k), 30000 - up, 30000 - up, 30000 + up, 30000 + up, 0);
      else
        chk($sformatf("t3.k%0d.m3", k), 32'(pwm_m3), 32'(30000 + up));
    end

    // Full throttle, roll error 10000 with default roll gains -> ur = 1581920>>8 = 6179
    sample("t4dis", 1'b0, 30000, 0, 0, 0, 0, 0, 4'd0, 16'd0);
    sample("t4", 1'b1, 65000, 0, 0, 10000, 0, 0, 4'd0, 16'd0);
    chk_out("t4", 58821, 65000, 58821, 65000, 1);

    // Roll Kp write while busy is dropped: ur = (100*100+10*100+50*100)>>8 = 62
    sample("t5dis", 1'b0, 30000, 0, 0, 0, 0, 0, 4'd0, 16'd0);
    sample("t5a", 1'b1, 30000, 0, 0, 100, 0, 2, 4'd3, 16'd0);
    chk_out("t5a", 29938, 30062, 29938, 30062, 0);
    // Write in the accept cycle is used: ur = (512*100 + 10*200 + 50*0)>>8 = 207
    sample("t5b", 1'b1, 30000, 0, 0, 100, 0, 1, 4'd3, 16'd512);
    chk_out("t5b", 29793, 30207, 29793, 30207, 0);

    // Disarm clears history: the next zero-error sample yields u = 0
    sample("t6dis", 1'b0, 30000, 0, 0, 100, 0, 0, 4'd0, 16'd0);
    chk_out("t6dis", 0, 0, 0, 0, 0);
    sample("t6clr", 1'b1, 30000, 0, 0, 0, 0, 0, 4'd0, 16'd0);
    chk_out("t6clr", 30000, 30000, 30000, 30000, 0);
    sample("t6min", 1'b1, 0, 0, 0, 0, 0, 0, 4'd0, 16'd0);
    chk_out("t6min", 256, 256, 256, 256, 1);

    // Reset during MAC cycle 4 aborts the sample
    wait_idle();
    arm = 1'b1; throttle = 16'd30000; target = '0; meas = '0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid.out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid.in_ready", 32'(in_ready), 32'd1);
    chk_out("rst_mid", 0, 0, 0, 0, 0);
    #20 rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("rst_mid.no_out_valid", 32'(seen), 32'd0);
    chk("rst_mid.hold_m4", 32'(pwm_m4), 32'd0);

    sample("t7", 1'b1, 30000, 0, 0, 0, 0, 0, 4'd0, 16'd0);
    chk_out("t7", 30000, 30000, 30000, 30000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
